stv_sync_fifo_wm: RTL and testbench
===================================

# stv_sync_fifo_wm

Synchronous ready/valid FIFO with a dedicated registered output stage, arbitrary depth, and run-time programmable almost-full/almost-empty watermarks. Next generation of the team's output-buffered FIFO: same registered-output guarantee for downstream timing, plus `DEPTH >= 2`, registered watermark flags for flow control of upstream producers, and optional high-water-mark telemetry. Sits between streaming pipeline stages and in front of credit/backpressure logic.

## Interface
- `data_t`, `logic [7:0]`, element type
- `DEPTH`, 8, total capacity including output register; must be >= 2
- `SKID`, 1'b0, 1 = `din_ready` depends only on registered state (no push when full, even with a same-cycle pop)
- `CNTWIDTH` (localparam), `$clog2(DEPTH+1)`, count/threshold width

- `clk`  in  1  clock, all logic on rising edge
- `arst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous flush, highest priority
- `din_valid`  in  1  push request
- `din_ready`  out  1  push accept
- `din`  in  data_t  push data
- `dout_valid`  out  1  output register holds data (registered)
- `dout_ready`  in  1  pop accept
- `dout`  out  data_t  output register (registered)
- `af_level`  in  CNTWIDTH  almost-full threshold
- `ae_level`  in  CNTWIDTH  almost-empty threshold
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `almost_full`  out  1  registered, count >= af_level
- `almost_empty`  out  1  registered, count <= ae_level
- `count`  out  CNTWIDTH  occupancy, 0..DEPTH
- `hwm`  out  CNTWIDTH  max occupancy since last clear (see Configuration)
- `hwm_clr`  in  1  reset `hwm` to current count

## Operation
- Storage: DEPTH-1 entry circular memory (rd/wr pointers wrap at DEPTH-1, non-power-of-2 supported) + one output register; DEPTH=2 gives 1-entry memory. Memory not reset.
- Push = `din_valid && din_ready`; pop = `dout_valid && dout_ready`.
- Output register loads, in order of precedence: memory head if memory non-empty; else `din` on push (bypass into empty output stage). Loads when output register empty or popped this cycle.
- `dout` only ever driven from output register; no combinational path din->dout.
- `din_ready`: SKID=0: `!clear && (!full || dout_ready)`; SKID=1: `!clear && !full`.
- `count` next = count + push - pop; maintained as a register.
- `almost_full`/`almost_empty` computed from next count and current level inputs, registered: valid in same cycle as `count`. `af_level = 0` forces almost_full = 1; `ae_level >= DEPTH` forces almost_empty = 1.
- `clear`: next cycle count = 0, pointers = 0, dout_valid = 0, empty = 1, full = 0, almost_full = (af_level == 0), almost_empty = 1, hwm = 0. Push blocked (din_ready = 0); any pop handshake in the clear cycle is discarded data.
- Reset values: dout_valid 0, dout 0, count 0, empty 1, full 0, almost_full 0, almost_empty 1, hwm 0, pointers 0.
- Reset mid-operation: all contents lost, reset values apply immediately (asynchronous).

## Timing
- Push to `dout_valid`: 1 cycle when empty (latency fixed, never 0).
- Pop to next element visible: same edge, if memory non-empty: back-to-back throughput 1/cycle.
- Full with push and pop same cycle: SKID=0 both accepted, count stays DEPTH; SKID=1 pop only, count -> DEPTH-1, push accepted next cycle.
- Level inputs sampled every cycle; changes reflected in flags one edge later.

## Configuration
- `STV_FIFO_HWM_EN` defined: `hwm` register tracks max(count) each cycle; `hwm_clr` sets hwm = next count; `clear` sets 0.
- Not defined: no hwm register; `hwm` tied 0, `hwm_clr` ignored. All other behaviour identical.

## Test plan
- DEPTH=4, push A at cycle 0 into empty FIFO -> dout_valid=1, dout=A, count=1 at cycle 1; empty falls same cycle.
- DEPTH=4, push 4 with dout_ready=0 -> full=1, count=4, din_ready=0 (SKID=1) / din_ready follows dout_ready (SKID=0); pop 4 returns in order.
- DEPTH=5 (non-power-of-2), 20 random push/pop cycles, pointers wrap -> ordering preserved, count never > 5.
- af_level=3, ae_level=1, DEPTH=4: count 0->4 -> almost_empty 1,1,0,0,0 and almost_full 0,0,0,1,1 aligned with count.
- Full FIFO, assert clear with din_valid=1 -> din_ready=0, next cycle count=0, dout_valid=0, hwm=0; arst_n low mid-stream -> reset values immediately.
- With STV_FIFO_HWM_EN: fill to 3, drain to 0 -> hwm=3; hwm_clr -> hwm=0; without macro hwm stays 0.

Source files
------------

// File: rtl/stv_sync_fifo_wm_if.sv
// ---------------------------------------------------------------------------
// stv_sync_fifo_wm_if
// Streaming bus for stv_sync_fifo_wm: push side (din_*) and pop side (dout_*).
//
// Handshake: a beat transfers on a rising clock edge when valid and ready are
// both high in that cycle. A source holds valid and data stable until the
// beat transfers. A sink may raise or lower ready at any time.
//
// Signals:
//   din_valid  - producer has a beat on din
//   din_ready  - FIFO accepts the beat on din
//   din        - push data
//   dout_valid - FIFO output register holds a beat
//   dout_ready - consumer accepts the beat on dout
//   dout       - pop data, always taken from the FIFO output register
//
// Modports: master = producer/consumer side (testbench, neighbouring stages),
//           slave  = FIFO side.
// ---------------------------------------------------------------------------
interface stv_sync_fifo_wm_if #(
    parameter type data_t = logic [7:0]
);
    logic  din_valid;
    logic  din_ready;
    data_t din;
    logic  dout_valid;
    logic  dout_ready;
    data_t dout;

    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout
    );

    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout
    );
endinterface

// File: rtl/stv_sync_fifo_wm.sv
// ---------------------------------------------------------------------------
// stv_sync_fifo_wm
// Synchronous FIFO with a registered output stage, any DEPTH >= 2, and
// run-time programmable almost-full / almost-empty watermarks.
// Storage is a (DEPTH-1)-entry circular memory plus one output register, so
// dout/dout_valid come straight from flops.
//
// Optional feature: define STV_FIFO_HWM_EN to build the high-water-mark
// register. Without it, hwm is tied to 0 and hwm_clr is ignored.
//
// Ports:
//   clk          - clock, rising edge
//   arst_n       - asynchronous active-low reset
//   clear        - synchronous flush, overrides everything else
//   bus          - push/pop handshake (slave modport of stv_sync_fifo_wm_if)
//   af_level     - almost-full threshold  (almost_full  = count >= af_level)
//   ae_level     - almost-empty threshold (almost_empty = count <= ae_level)
//   empty, full  - count == 0, count == DEPTH
//   almost_full  - registered, aligned with count
//   almost_empty - registered, aligned with count
//   count        - occupancy including the output register, 0..DEPTH
//   hwm          - highest occupancy since last clear / hwm_clr
//   hwm_clr      - load hwm with the occupancy of the next cycle
// Parameters: data_t, DEPTH (>= 2), SKID (1 = din_ready from state only).
// ---------------------------------------------------------------------------
module stv_sync_fifo_wm #(
    parameter type data_t   = logic [7:0],
    parameter int  DEPTH    = 8,
    parameter bit  SKID     = 1'b0,
    localparam int CNTWIDTH = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                clear,
    stv_sync_fifo_wm_if.slave   bus,
    input  logic [CNTWIDTH-1:0] af_level,
    input  logic [CNTWIDTH-1:0] ae_level,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [CNTWIDTH-1:0] count,
    output logic [CNTWIDTH-1:0] hwm,
    input  logic                hwm_clr
);
    localparam int MEMD = DEPTH - 1;
    localparam int PW   = (MEMD > 1) ? $clog2(MEMD) : 1;

    data_t               mem [MEMD];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CNTWIDTH-1:0] mem_cnt;
    logic [CNTWIDTH-1:0] count_q;
    logic [CNTWIDTH-1:0] cnt_nxt;
    data_t               dout_q;
    logic                dout_valid_q;
    logic                af_q;
    logic                ae_q;

    logic push;
    logic pop;
    logic out_load;
    logic mem_has;
    logic mem_rd;
    logic mem_wr;
    logic full_w;

    // Pointers wrap at MEMD-1 so non-power-of-2 memories work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MEMD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_w        = (count_q == CNTWIDTH'(DEPTH));
    // SKID=0 lets a push in while full when the head is being popped.
    assign bus.din_ready = !clear && (!full_w || (!SKID && bus.dout_ready));

    assign push     = bus.din_valid && bus.din_ready;
    assign pop      = dout_valid_q && bus.dout_ready;
    assign mem_has  = (mem_cnt != '0);
    assign out_load = !dout_valid_q || pop;
    // The output register always refills from the memory head first; a push
    // bypasses the memory only when the memory is empty and the register
    // is free this cycle.
    assign mem_rd   = out_load && mem_has;
    assign mem_wr   = push && !(out_load && !mem_has);
    assign cnt_nxt  = clear ? '0 : (count_q + CNTWIDTH'(push) - CNTWIDTH'(pop));

    // Memory contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_cnt      <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            af_q         <= 1'b0;
            ae_q         <= 1'b1;
        end else begin
            // Flags track the next count, so they line up with count_q.
            af_q <= (cnt_nxt >= af_level);
            ae_q <= (cnt_nxt <= ae_level);
            if (clear) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                mem_cnt      <= '0;
                count_q      <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                count_q <= cnt_nxt;
                mem_cnt <= mem_cnt + CNTWIDTH'(mem_wr) - CNTWIDTH'(mem_rd);
                if (mem_wr) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (mem_rd) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (out_load) begin
                    if (mem_has) begin
                        dout_q       <= mem[rd_ptr];
                        dout_valid_q <= 1'b1;
                    end else if (push) begin
                        dout_q       <= bus.din;
                        dout_valid_q <= 1'b1;
                    end else begin
                        dout_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef STV_FIFO_HWM_EN
    logic [CNTWIDTH-1:0] hwm_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hwm_q <= '0;
        end else if (clear) begin
            hwm_q <= '0;
        end else if (hwm_clr) begin
            hwm_q <= cnt_nxt;
        end else if (cnt_nxt > hwm_q) begin
            hwm_q <= cnt_nxt;
        end
    end

    assign hwm = hwm_q;
`else
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
    assign hwm            = '0;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign count          = count_q;
    assign empty          = (count_q == '0);
    assign full           = full_w;
    assign almost_full    = af_q;
    assign almost_empty   = ae_q;
endmodule

// File: tb/tb_stv_sync_fifo_wm.sv
// ---------------------------------------------------------------------------
// tb_stv_sync_fifo_wm
// Two FIFOs driven by the same stimulus: u_a (DEPTH=4, SKID=1) and
// u_b (DEPTH=5, SKID=0). A queue-based model predicts occupancy, ordering,
// flags and hwm for each instance.
// ---------------------------------------------------------------------------
module tb_stv_sync_fifo_wm;
    localparam int W  = 3;
    localparam int D0 = 4;
    localparam int D1 = 5;
`ifdef STV_FIFO_HWM_EN
    localparam bit HWM_EN = 1'b1;
`else
    localparam bit HWM_EN = 1'b0;
`endif
    // {dout_valid, empty, full, almost_full, almost_empty, count, hwm}
    localparam logic [10:0] RST_STAT = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0};

    // ---------------- clock / reset / inputs ----------------
    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         clear = 1'b0;
    logic         hwm_clr = 1'b0;
    logic         din_valid = 1'b0;
    logic [7:0]   din = '0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] af_level = 3'd3;
    logic [W-1:0] ae_level = 3'd1;

    always #5 clk = ~clk;

    stv_sync_fifo_wm_if bus_a ();
    stv_sync_fifo_wm_if bus_b ();

    assign bus_a.din_valid  = din_valid;
    assign bus_a.din        = din;
    assign bus_a.dout_ready = dout_ready;
    assign bus_b.din_valid  = din_valid;
    assign bus_b.din        = din;
    assign bus_b.dout_ready = dout_ready;

    logic         empty_a, full_a, af_a, ae_a;
    logic         empty_b, full_b, af_b, ae_b;
    logic [W-1:0] count_a, hwm_a, count_b, hwm_b;
    logic [10:0]  stat_a, stat_b;

    stv_sync_fifo_wm #(.DEPTH(D0), .SKID(1'b1)) u_a (
        .clk(clk), .arst_n(arst_n), .clear(clear), .bus(bus_a),
        .af_level(af_level), .ae_level(ae_level),
        .empty(empty_a), .full(full_a), .almost_full(af_a), .almost_empty(ae_a),
        .count(count_a), .hwm(hwm_a), .hwm_clr(hwm_clr)
    );

    stv_sync_fifo_wm #(.DEPTH(D1), .SKID(1'b0)) u_b (
        .clk(clk), .arst_n(arst_n), .clear(clear), .bus(bus_b),
        .af_level(af_level), .ae_level(ae_level),
        .empty(empty_b), .full(full_b), .almost_full(af_b), .almost_empty(ae_b),
        .count(count_b), .hwm(hwm_b), .hwm_clr(hwm_clr)
    );

    assign stat_a = {bus_a.dout_valid, empty_a, full_a, af_a, ae_a, count_a, hwm_a};
    assign stat_b = {bus_b.dout_valid, empty_b, full_b, af_b, ae_b, count_b, hwm_b};

    // ---------------- reference model ----------------
    logic [7:0]   q0[$];
    logic [7:0]   q1[$];
    logic [W-1:0] hwm_m[2];
    logic         af_m[2];
    logic         ae_m[2];
    int           n_checks = 0;
    int           n_fail = 0;

    function automatic int qsz(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int dep(int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic bit skid(int i);
        return (i == 0);
    endfunction

    function automatic logic exp_ready(int i);
        if (clear) return 1'b0;
        if (qsz(i) < dep(i)) return 1'b1;
        return skid(i) ? 1'b0 : dout_ready;
    endfunction

    function automatic logic [7:0] exp_front(int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic logic [10:0] exp_status(int i);
        int sz = qsz(i);
        return {sz > 0, sz == 0, sz == dep(i), af_m[i], ae_m[i], W'(sz),
                HWM_EN ? hwm_m[i] : W'(0)};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            hwm_m[i] = '0;
            af_m[i]  = 1'b0;
            ae_m[i]  = 1'b1;
        end
    endtask

    // Advance the model with the current inputs, then let the DUTs take the
    // same clock edge. Returns 1 time unit after the edge.
    task automatic tick();
        logic rdy[2];
        int   sz;
        for (int i = 0; i < 2; i++) rdy[i] = exp_ready(i);
        for (int i = 0; i < 2; i++) begin
            logic pu, po;
            pu = din_valid && rdy[i];
            po = (qsz(i) > 0) && dout_ready;
            if (clear) begin
                if (i == 0) q0.delete(); else q1.delete();
            end else begin
                if (po) begin
                    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
                if (pu) begin
                    if (i == 0) q0.push_back(din); else q1.push_back(din);
                end
            end
            sz = qsz(i);
            af_m[i] = (sz >= int'(af_level));
            ae_m[i] = (sz <= int'(ae_level));
            if (clear)                      hwm_m[i] = '0;
            else if (hwm_clr)               hwm_m[i] = W'(sz);
            else if (sz > int'(hwm_m[i]))   hwm_m[i] = W'(sz);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        clear      = 1'b0;
        hwm_clr    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        af_level = 3'd3;
        ae_level = 3'd1;
        arst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        n_checks++; if (stat_a !== RST_STAT) begin n_fail++; $display("FAIL reset_stat_a: got %b want %b", stat_a, RST_STAT); end
        n_checks++; if (stat_b !== RST_STAT) begin n_fail++; $display("FAIL reset_stat_b: got %b want %b", stat_b, RST_STAT); end
        n_checks++; if (bus_a.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout_a: got %h want 00", bus_a.dout); end
        n_checks++; if (bus_b.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout_b: got %h want 00", bus_b.dout); end
    endtask

    task automatic test_bypass_latency();
        din = 8'hA5; din_valid = 1'b1; dout_ready = 1'b0;
        #1;
        n_checks++; if (bus_a.din_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready_a: got %b want 1", bus_a.din_ready); end
        n_checks++; if (bus_a.dout_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_no_zero_latency: got %b want 0", bus_a.dout_valid); end
        tick();
        din_valid = 1'b0;
        n_checks++; if (bus_a.dout_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_dv_a: got %b want 1", bus_a.dout_valid); end
        n_checks++; if (bus_a.dout !== 8'hA5) begin n_fail++; $display("FAIL bypass_dout_a: got %h want a5", bus_a.dout); end
        n_checks++; if (count_a !== 3'd1 || empty_a !== 1'b0) begin n_fail++; $display("FAIL bypass_count_a: got count %0d empty %b want 1 0", count_a, empty_a); end
        n_checks++; if (stat_b !== exp_status(1)) begin n_fail++; $display("FAIL bypass_stat_b: got %b want %b", stat_b, exp_status(1)); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        n_checks++; if (stat_a !== exp_status(0)) begin n_fail++; $display("FAIL bypass_pop_a: got %b want %b", stat_a, exp_status(0)); end
    endtask

    task automatic test_fill_full();
        dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din = 8'($urandom); din_valid = 1'b1;
            #1;
            n_checks++; if (bus_a.din_ready !== exp_ready(0)) begin n_fail++; $display("FAIL fill_ready_a[%0d]: got %b want %b", k, bus_a.din_ready, exp_ready(0)); end
            n_checks++; if (bus_b.din_ready !== exp_ready(1)) begin n_fail++; $display("FAIL fill_ready_b[%0d]: got %b want %b", k, bus_b.din_ready, exp_ready(1)); end
            tick();
        end
        n_checks++; if (full_a !== 1'b1 || count_a !== 3'd4) begin n_fail++; $display("FAIL full_a: got full %b count %0d want 1 4", full_a, count_a); end
        n_checks++; if (full_b !== 1'b1 || count_b !== 3'd5) begin n_fail++; $display("FAIL full_b: got full %b count %0d want 1 5", full_b, count_b); end
        din_valid = 1'b1; din = 8'h3C;
        #1;
        n_checks++; if (bus_a.din_ready !== 1'b0 || bus_b.din_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_noread: got a %b b %b want 0 0", bus_a.din_ready, bus_b.din_ready); end
        dout_ready = 1'b1;
        #1;
        n_checks++; if (bus_a.din_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_skid_a: got %b want 0", bus_a.din_ready); end
        n_checks++; if (bus_b.din_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_follow_b: got %b want 1", bus_b.din_ready); end
        tick();
        n_checks++; if (count_a !== 3'd3) begin n_fail++; $display("FAIL full_pushpop_a: got count %0d want 3", count_a); end
        n_checks++; if (count_b !== 3'd5) begin n_fail++; $display("FAIL full_pushpop_b: got count %0d want 5", count_b); end
        dout_ready = 1'b0; din = 8'h5A;
        #1;
        n_checks++; if (bus_a.din_ready !== 1'b1) begin n_fail++; $display("FAIL skid_next_ready_a: got %b want 1", bus_a.din_ready); end
        tick();
        din_valid = 1'b0; dout_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (qsz(0) > 0 && bus_a.dout !== exp_front(0)) begin n_fail++; $display("FAIL drain_dout_a[%0d]: got %h want %h", k, bus_a.dout, exp_front(0)); end
            n_checks++; if (qsz(1) > 0 && bus_b.dout !== exp_front(1)) begin n_fail++; $display("FAIL drain_dout_b[%0d]: got %h want %h", k, bus_b.dout, exp_front(1)); end
            tick();
            n_checks++; if (stat_a !== exp_status(0)) begin n_fail++; $display("FAIL drain_stat_a[%0d]: got %b want %b", k, stat_a, exp_status(0)); end
            n_checks++; if (stat_b !== exp_status(1)) begin n_fail++; $display("FAIL drain_stat_b[%0d]: got %b want %b", k, stat_b, exp_status(1)); end
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_watermarks();
        logic ae_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic af_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        af_level = 3'd3; ae_level = 3'd1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (count_a !== W'(k) || ae_a !== ae_tab[k] || af_a !== af_tab[k]) begin
                n_fail++; $display("FAIL wm_a[%0d]: got count %0d ae %b af %b want %0d %b %b", k, count_a, ae_a, af_a, k, ae_tab[k], af_tab[k]);
            end
            din = 8'($urandom); din_valid = (k < 4); dout_ready = 1'b0;
            tick();
        end
        din_valid = 1'b0;
        af_level = 3'd0; ae_level = 3'd7;
        tick();
        n_checks++; if (af_a !== 1'b1 || ae_a !== 1'b1) begin n_fail++; $display("FAIL wm_force_a: got af %b ae %b want 1 1", af_a, ae_a); end
        n_checks++; if (stat_b !== exp_status(1)) begin n_fail++; $display("FAIL wm_force_b: got %b want %b", stat_b, exp_status(1)); end
        af_level = 3'd3; ae_level = 3'd1;
        tick();
        n_checks++; if (stat_a !== exp_status(0)) begin n_fail++; $display("FAIL wm_restore_a: got %b want %b", stat_a, exp_status(0)); end
    endtask

    task automatic test_clear();
        clear = 1'b1; din_valid = 1'b1; dout_ready = 1'b1; din = 8'hEE;
        #1;
        n_checks++; if (bus_a.din_ready !== 1'b0 || bus_b.din_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got a %b b %b want 0 0", bus_a.din_ready, bus_b.din_ready); end
        tick();
        clear = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        n_checks++; if (count_a !== 3'd0 || bus_a.dout_valid !== 1'b0 || hwm_a !== 3'd0 || af_a !== 1'b0 || ae_a !== 1'b1) begin
            n_fail++; $display("FAIL clear_a: got count %0d dv %b hwm %0d af %b ae %b want 0 0 0 0 1", count_a, bus_a.dout_valid, hwm_a, af_a, ae_a);
        end
        n_checks++; if (stat_b !== exp_status(1)) begin n_fail++; $display("FAIL clear_b: got %b want %b", stat_b, exp_status(1)); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 80; c++) begin
            din        = 8'($urandom);
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            clear      = ($urandom_range(0, 29) == 0);
            hwm_clr    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                af_level = W'($urandom_range(0, 7));
                ae_level = W'($urandom_range(0, 7));
            end
            #1;
            n_checks++; if (bus_a.din_ready !== exp_ready(0)) begin n_fail++; $display("FAIL rand_ready_a[%0d]: got %b want %b", c, bus_a.din_ready, exp_ready(0)); end
            n_checks++; if (bus_b.din_ready !== exp_ready(1)) begin n_fail++; $display("FAIL rand_ready_b[%0d]: got %b want %b", c, bus_b.din_ready, exp_ready(1)); end
            tick();
            n_checks++; if (stat_a !== exp_status(0)) begin n_fail++; $display("FAIL rand_stat_a[%0d]: got %b want %b", c, stat_a, exp_status(0)); end
            n_checks++; if (stat_b !== exp_status(1)) begin n_fail++; $display("FAIL rand_stat_b[%0d]: got %b want %b", c, stat_b, exp_status(1)); end
            n_checks++; if (qsz(0) > 0 && bus_a.dout !== exp_front(0)) begin n_fail++; $display("FAIL rand_dout_a[%0d]: got %h want %h", c, bus_a.dout, exp_front(0)); end
            n_checks++; if (qsz(1) > 0 && bus_b.dout !== exp_front(1)) begin n_fail++; $display("FAIL rand_dout_b[%0d]: got %h want %h", c, bus_b.dout, exp_front(1)); end
            n_checks++; if (count_b > 3'd5) begin n_fail++; $display("FAIL rand_bound_b[%0d]: got count %0d want <= 5", c, count_b); end
        end
        idle_inputs();
        af_level = 3'd3; ae_level = 3'd1;
    endtask

    task automatic test_hwm();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        din_valid = 1'b1; dout_ready = 1'b0;
        repeat (3) begin din = 8'($urandom); tick(); end
        din_valid = 1'b0; dout_ready = 1'b1;
        repeat (3) tick();
        dout_ready = 1'b0;
        n_checks++; if (hwm_a !== (HWM_EN ? 3'd3 : 3'd0) || count_a !== 3'd0) begin
            n_fail++; $display("FAIL hwm_peak_a: got hwm %0d count %0d want %0d 0", hwm_a, count_a, HWM_EN ? 3 : 0);
        end
        n_checks++; if (stat_b !== exp_status(1)) begin n_fail++; $display("FAIL hwm_peak_b: got %b want %b", stat_b, exp_status(1)); end
        hwm_clr = 1'b1;
        tick();
        hwm_clr = 1'b0;
        n_checks++; if (hwm_a !== 3'd0 || hwm_b !== 3'd0) begin n_fail++; $display("FAIL hwm_clr: got a %0d b %0d want 0 0", hwm_a, hwm_b); end
    endtask

    task automatic test_async_reset();
        din_valid = 1'b1; dout_ready = 1'b0;
        repeat (2) begin din = 8'($urandom); tick(); end
        #3;
        arst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (stat_a !== RST_STAT) begin n_fail++; $display("FAIL arst_stat_a: got %b want %b", stat_a, RST_STAT); end
        n_checks++; if (stat_b !== RST_STAT) begin n_fail++; $display("FAIL arst_stat_b: got %b want %b", stat_b, RST_STAT); end
        n_checks++; if (bus_a.dout !== 8'h00) begin n_fail++; $display("FAIL arst_dout_a: got %h want 00", bus_a.dout); end
        din_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        din = 8'h77; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        n_checks++; if (stat_a !== exp_status(0) || bus_a.dout !== 8'h77) begin n_fail++; $display("FAIL arst_after_a: got %b %h want %b 77", stat_a, bus_a.dout, exp_status(0)); end
    endtask

    initial begin
        test_reset();
        test_bypass_latency();
        test_fill_full();
        test_watermarks();
        test_clear();
        test_random();
        test_hwm();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
